// File: rtl/wait_state_gen.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
//  Module   : wait_state_gen
//  Purpose  : Decodes each memory / I/O access as it starts, looks up a
//             per-window wait count and holds the open-drain nws request low
//             for exactly that many clock cycles. Counts inserted waits.
//  Revision : 1.0  initial release
// ============================================================================
module wait_state_gen #(
  parameter int                 ADDR_W    = 24,
  parameter logic [ADDR_W-1:0]  BASE0     = 24'h000000,
  parameter logic [ADDR_W-1:0]  MASK0     = 24'hFF8000,
  parameter logic [ADDR_W-1:0]  BASE1     = 24'h200000,
  parameter logic [ADDR_W-1:0]  MASK1     = 24'hF00000,
  parameter logic [3:0]         WS0_INIT  = 4'd2,
  parameter logic [3:0]         WS1_INIT  = 4'd0,
  parameter logic [3:0]         WSIO_INIT = 4'd1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              nmem,
  input  logic              nio,
  input  logic [ADDR_W-1:0] ab,
  output logic              nws,
  input  logic              cfg_we,
  input  logic [1:0]        cfg_sel,
  input  logic [3:0]        cfg_data,
  output logic              ws_busy,
  output logic [15:0]       ws_total
);

  localparam logic [1:0]  c_IDLE    = 2'd0;
  localparam logic [1:0]  c_WAIT    = 2'd1;
  localparam logic [1:0]  c_HOLD    = 2'd2;
  localparam logic [15:0] c_SAT_MAX = 16'hFFFF;

  logic [1:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        acc_q;
  logic [3:0]  ws0_q, ws0_d;
  logic [3:0]  ws1_q, ws1_d;
  logic [3:0]  wsio_q, wsio_d;
  logic [15:0] total_q, total_d;

  logic        acc;
  logic        start;
  logic [3:0]  lookup;

  assign acc   = ~nmem | ~nio;
  assign start = acc & ~acc_q;

  // Window decode; I/O takes priority so a simultaneous nmem/nio is I/O.
  // The registered counts are read here, so a config write on the start
  // edge only affects later accesses.
  always_comb begin
    lookup = 4'd0;
    if (!nio) begin
      lookup = wsio_q;
    end else if ((ab & MASK0) == BASE0) begin
      lookup = ws0_q;
    end else if ((ab & MASK1) == BASE1) begin
      lookup = ws1_q;
    end
  end

  // State, counter, config and statistics registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= c_IDLE;
      cnt_q   <= 4'd0;
      acc_q   <= 1'b0;
      ws0_q   <= WS0_INIT;
      ws1_q   <= WS1_INIT;
      wsio_q  <= WSIO_INIT;
      total_q <= 16'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc;
      ws0_q   <= ws0_d;
      ws1_q   <= ws1_d;
      wsio_q  <= wsio_d;
      total_q <= total_d;
    end
  end

  // Next-state and wait counter: the counter is only loaded on a start edge,
  // never by a config write, so an in-flight wait always runs to completion.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      c_IDLE: begin
        if (start && (lookup != 4'd0)) begin
          cnt_d   = lookup;
          state_d = c_WAIT;
        end
      end
      c_WAIT: begin
        if (!acc) begin
          state_d = c_IDLE;
        end else if (cnt_q > 4'd1) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d = c_HOLD;
        end
      end
      c_HOLD: begin
        if (!acc) begin
          state_d = c_IDLE;
        end
      end
      default: begin
        state_d = c_IDLE;
      end
    endcase
  end

  // Config register writes and the saturating wait-cycle counter; a clear
  // request overrides an increment on the same edge.
  always_comb begin
    ws0_d   = ws0_q;
    ws1_d   = ws1_q;
    wsio_d  = wsio_q;
    total_d = total_q;
    if ((state_d == c_WAIT) && (total_q != c_SAT_MAX)) begin
      total_d = total_q + 16'd1;
    end
    if (cfg_we) begin
      case (cfg_sel)
        2'd0:    ws0_d   = cfg_data;
        2'd1:    ws1_d   = cfg_data;
        2'd2:    wsio_d  = cfg_data;
        default: total_d = 16'd0;
      endcase
    end
  end

  // Outputs: nws only ever pulls low, and only while waiting.
  always_comb begin
    ws_busy  = (state_q == c_WAIT);
    nws      = ws_busy ? 1'b0 : 1'bz;
    ws_total = total_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_wait_state_gen.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
//  Module   : tb_wait_state_gen
//  Purpose  : Directed self-checking bench for wait_state_gen.
//  Revision : 1.0  initial release
// ============================================================================
module tb_wait_state_gen;

  logic        clk;
  logic        reset;
  logic        nmem;
  logic        nio;
  logic [23:0] ab;
  logic        cfg_we;
  logic [1:0]  cfg_sel;
  logic [3:0]  cfg_data;
  logic        ws_busy;
  logic [15:0] ws_total;
  wire         nws;

  int checks = 0;
  int errors = 0;
  int n;

  // External pull-up on the open-drain wait line: released reads as 1.
  pullup (nws);

  wait_state_gen dut (
    .clk      (clk),
    .reset    (reset),
    .nmem     (nmem),
    .nio      (nio),
    .ab       (ab),
    .nws      (nws),
    .cfg_we   (cfg_we),
    .cfg_sel  (cfg_sel),
    .cfg_data (cfg_data),
    .ws_busy  (ws_busy),
    .ws_total (ws_total)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1500000;
    $display("FAIL timeout: observed no finish, expected finish");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cfg(input logic [1:0] sel, input logic [3:0] data);
    cfg_we   = 1'b1;
    cfg_sel  = sel;
    cfg_data = data;
    tick();
    cfg_we   = 1'b0;
  endtask

  task automatic count_low(input int cycles, output int lows);
    lows = 0;
    repeat (cycles) begin
      tick();
      if (nws === 1'b0) lows++;
    end
  endtask

  initial begin
    reset = 1'b1; nmem = 1'b1; nio = 1'b1; ab = '0;
    cfg_we = 1'b0; cfg_sel = 2'd0; cfg_data = 4'd0;
    tick(); tick();
    check("rst_nws", {31'd0, nws}, 32'd1);
    check("rst_busy", {31'd0, ws_busy}, 32'd0);
    check("rst_total", {16'd0, ws_total}, 32'd0);
    reset = 1'b0;
    tick();

    // Window 0 (ROM), WS0 = 2
    nmem = 1'b0; ab = 24'h000100;
    tick();
    check("w0_e1_nws", {31'd0, nws}, 32'd0);
    check("w0_e1_total", {16'd0, ws_total}, 32'd1);
    tick();
    check("w0_e2_nws", {31'd0, nws}, 32'd0);
    tick();
    check("w0_e3_nws", {31'd0, nws}, 32'd1);
    check("w0_e3_busy", {31'd0, ws_busy}, 32'd0);
    repeat (3) tick();
    check("w0_hold_nws", {31'd0, nws}, 32'd1);
    check("w0_total", {16'd0, ws_total}, 32'd2);
    nmem = 1'b1;
    tick();

    // I/O access (WSIO = 1), address would otherwise decode as window 0
    nio = 1'b0; ab = 24'h000010;
    tick();
    check("io_e1_nws", {31'd0, nws}, 32'd0);
    tick();
    check("io_e2_nws", {31'd0, nws}, 32'd1);
    check("io_total", {16'd0, ws_total}, 32'd3);
    nio = 1'b1;
    tick();

    // Unmapped memory: no wait
    nmem = 1'b0; ab = 24'h300000;
    count_low(4, n);
    check("unmapped_lows", n, 32'd0);
    check("unmapped_total", {16'd0, ws_total}, 32'd3);
    nmem = 1'b1;
    tick();

    // WS1 = 15; rewrite to 3 mid-wait must not shorten it
    cfg(2'd1, 4'd15);
    nmem = 1'b0; ab = 24'h2ABCDE;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      cfg_we = (i == 2); cfg_sel = 2'd1; cfg_data = 4'd3;
      tick();
      if (nws === 1'b0) n++;
    end
    cfg_we = 1'b0;
    check("w1_15_lows", n, 32'd15);
    check("w1_15_total", {16'd0, ws_total}, 32'd18);
    nmem = 1'b1;
    tick();
    nmem = 1'b0; ab = 24'h200000;
    count_low(6, n);
    check("w1_3_lows", n, 32'd3);
    check("w1_3_total", {16'd0, ws_total}, 32'd21);
    nmem = 1'b1;
    tick();

    // Aborted window-0 access with WS0 = 4
    cfg(2'd0, 4'd4);
    nmem = 1'b0; ab = 24'h000100;
    tick();
    check("abort_busy", {31'd0, ws_busy}, 32'd1);
    nmem = 1'b1;
    tick();
    check("abort_nws", {31'd0, nws}, 32'd1);
    check("abort_busy_off", {31'd0, ws_busy}, 32'd0);
    check("abort_total", {16'd0, ws_total}, 32'd22);
    nmem = 1'b0;
    count_low(8, n);
    check("after_abort_lows", n, 32'd4);
    check("after_abort_total", {16'd0, ws_total}, 32'd26);
    nmem = 1'b1;
    tick();

    // Asynchronous reset in the middle of a 10-cycle wait
    cfg(2'd0, 4'd10);
    nmem = 1'b0; ab = 24'h000100;
    repeat (4) tick();
    check("pre_rst_busy", {31'd0, ws_busy}, 32'd1);
    #2 reset = 1'b1;
    #1;
    check("async_rst_nws", {31'd0, nws}, 32'd1);
    check("async_rst_busy", {31'd0, ws_busy}, 32'd0);
    check("async_rst_total", {16'd0, ws_total}, 32'd0);
    nmem = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    nmem = 1'b0; ab = 24'h000100;
    count_low(5, n);
    check("ws0_init_lows", n, 32'd2);
    nmem = 1'b1;
    tick();
    nmem = 1'b0; ab = 24'h200000;
    count_low(3, n);
    check("ws1_init_lows", n, 32'd0);
    nmem = 1'b1;
    tick();
    check("post_rst_total", {16'd0, ws_total}, 32'd2);

    // Clear, then saturate ws_total
    cfg(2'd3, 4'd0);
    check("clear_total", {16'd0, ws_total}, 32'd0);
    cfg(2'd1, 4'd15);
    ab = 24'h200000;
    for (int k = 0; k < 4368; k++) begin
      nmem = 1'b0;
      repeat (15) tick();
      nmem = 1'b1;
      tick();
    end
    check("preload_fff0", {16'd0, ws_total}, 32'h0000FFF0);
    cfg(2'd1, 4'd14);
    nmem = 1'b0;
    repeat (14) tick();
    nmem = 1'b1;
    tick();
    check("preload_fffe", {16'd0, ws_total}, 32'h0000FFFE);
    cfg(2'd1, 4'd2);
    nmem = 1'b0;
    tick();
    check("sat_e1", {16'd0, ws_total}, 32'h0000FFFF);
    tick();
    check("sat_e2", {16'd0, ws_total}, 32'h0000FFFF);
    check("sat_e2_busy", {31'd0, ws_busy}, 32'd1);
    tick();
    check("sat_hold", {16'd0, ws_total}, 32'h0000FFFF);
    check("sat_hold_nws", {31'd0, nws}, 32'd1);
    nmem = 1'b1;
    tick();

    // Clear coinciding with a counting edge: clear wins
    nmem = 1'b0; cfg_we = 1'b1; cfg_sel = 2'd3; cfg_data = 4'd0;
    tick();
    check("clear_wins", {16'd0, ws_total}, 32'd0);
    check("clear_wins_busy", {31'd0, ws_busy}, 32'd1);
    cfg_we = 1'b0;
    tick();
    check("count_after_clear", {16'd0, ws_total}, 32'd1);
    nmem = 1'b1;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/wait_state_gen.md
Name: wait_state_gen

Overview:
- Upstream neighbour of the data bus interface; it generates the open-drain nWS wait-state request that the data bus's wait state flip-flop consumes.
- Decodes each memory or I/O access as it starts and looks up a per-window wait count.
- Holds nWS low for exactly that many clock cycles, so slow devices (ROM, slow I/O cards) get extra time without their own wait logic.
- Counts inserted wait cycles for diagnostics.

Parameters:
ADDR_W, 24, address bus width
BASE0, 24'h000000, window 0 base address (ROM)
MASK0, 24'hFF8000, window 0 compare mask
BASE1, 24'h200000, window 1 base address
MASK1, 24'hF00000, window 1 compare mask
WS0_INIT, 4'd2, reset wait count for window 0
WS1_INIT, 4'd0, reset wait count for window 1
WSIO_INIT, 4'd1, reset wait count for all I/O accesses

Ports:
clk  input  1  processor cycle clock; all state changes on rising edge
reset  input  1  asynchronous, active-high reset
nmem  input  1  memory access strobe, active low
nio  input  1  I/O access strobe, active low
ab  input  ADDR_W  address bus, valid while nmem/nio low
nws  output  1  wait request, open-drain: drives 0 or z, never 1
cfg_we  input  1  configuration write strobe, active high
cfg_sel  input  2  0=WS0, 1=WS1, 2=WSIO, 3=clear ws_total
cfg_data  input  4  new wait count
ws_busy  output  1  high while nws is driven low
ws_total  output  16  saturating count of wait cycles inserted

Behaviour:
- Interface: one clock, clk. Reset is asynchronous and active-high, named reset.
- Reset (async, immediate):
  - nws=z; state=IDLE; cnt=0; acc_q=0; ws_total=0; ws_busy=0.
  - WS0/WS1/WSIO registers load WS0_INIT/WS1_INIT/WSIO_INIT.
  - Reset asserted mid-wait releases nws at once, with no further cycles.
- acc = ~nmem | ~nio. acc_q is acc registered on clk. start = acc & ~acc_q (the first edge of an access).
- Lookup, combinational at the start edge, first match wins:
  - nio low -> WSIO
  - else (ab & MASK0)==BASE0 -> WS0
  - else (ab & MASK1)==BASE1 -> WS1
  - else 0
  - nio and nmem both low is treated as I/O.
- States:
  - IDLE: on start with N=lookup.
    - N==0: stay IDLE; nws stays z.
    - N>0: cnt<=N, nws<=0, go to WAIT.
  - WAIT: each edge, if acc still high:
    - cnt>1: cnt<=cnt-1.
    - cnt==1: nws<=z, go to HOLD.
    - Result: nws is low for exactly N rising-edge-to-rising-edge cycles.
    - If acc drops during WAIT (aborted access): nws<=z, go to IDLE on that edge.
  - HOLD: stay until acc==0, then IDLE. A new access cannot retrigger without acc first going low (back-to-back strobes need at least one high cycle sampled).
- ws_busy = (state==WAIT). nws is driven low only in WAIT.
- ws_total: +1 on every edge that ends with state WAIT; saturates at 16'hFFFF, no wrap.
- Configuration:
  - cfg_we sampled on clk.
  - sel 0..2 writes the register at that edge; takes effect for accesses starting on later edges.
  - A write coinciding with a start edge: the lookup uses the old value.
  - sel 3 clears ws_total. If it coincides with an increment, the clear wins and the result is 0.
  - A write of 0 disables waits for that window.
- A count in WAIT is never reloaded mid-access by a config write.
- Width rules: cnt is 4 bits; the maximum wait is 15 cycles.

Test Plan:
- Reset, then nmem low with ab=24'h000100 held 6 cycles -> nws low exactly 2 cycles starting at the first edge, then z; ws_total=2; remains z for the rest of the access.
- nio low with ab=24'h000010 -> nws low 1 cycle; ab=24'h300000 with nmem -> no wait, nws z throughout, ws_total unchanged.
- cfg_we, sel=1, data=15; then access ab=24'h2ABCDE -> nws low 15 cycles; cfg write of WS1=3 issued during that wait does not shorten it; the next window-1 access waits 3.
- Window-0 access aborted: nmem high after 1 wait cycle with WS0=4 -> nws released on that edge, state IDLE; a following access waits the full 4.
- Assert reset in the middle of a 10-cycle wait -> nws z immediately (asynchronous), WS registers return to INIT values, ws_total=0.
- Preload via repeated accesses until ws_total=16'hFFFE, then a 2-wait access -> ws_total=16'hFFFF, no wrap; cfg sel=3 on a counting edge -> 0.
